// File: rtl/time_sensitive_injection_scheduler_pkg.sv
// Shared definitions for the time-sensitive injection scheduler:
// schedule entry field positions, table geometry and FSM state encodings.
package time_sensitive_injection_scheduler_pkg;

  localparam int ENTRY_VALID_BIT = 15;
  localparam int FLOWID_MSB      = 13;
  localparam int FLOWID_LSB      = 0;
  localparam int ENTRY_RSVD_BIT  = 14;
  localparam int FLOWID_W        = FLOWID_MSB - FLOWID_LSB + 1;

  localparam int TABLE_DEPTH     = 1024;
  localparam int IDX_W           = $clog2(TABLE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/tsi_slot_tracker.sv
// Slot tracker: detects slot boundaries as toggles of the selected global
// time bit, gates them with enable/period, and keeps the wrapping slot index.
module tsi_slot_tracker
  import time_sensitive_injection_scheduler_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_time_bit,
  input  logic             i_sched_en,
  input  logic [IDX_W-1:0] iv_period,
  output logic             o_boundary,
  output logic [IDX_W-1:0] ov_slot_idx
);

  logic             r_prev_bit;
  logic             r_armed;
  logic [IDX_W-1:0] r_slot_idx;

  logic             w_active;
  logic             w_toggle;
  logic [IDX_W-1:0] w_last_idx;
  logic             w_wrap;

  // The first cycle after reset only captures the time bit (r_armed=0),
  // so a stale previous value can never look like a boundary.
  assign w_active   = i_sched_en && (iv_period != '0);
  assign w_toggle   = r_armed && (i_time_bit != r_prev_bit);
  assign o_boundary = w_toggle && w_active && !i_rst;

  // ">=" rather than "==" so a period that shrank below the index wraps too.
  assign w_last_idx = iv_period - IDX_W'(1);
  assign w_wrap     = (r_slot_idx >= w_last_idx);

  assign ov_slot_idx = r_slot_idx;

  // Track previous time bit and advance/wrap the slot index on each boundary.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev_bit <= 1'b0;
      r_armed    <= 1'b0;
      r_slot_idx <= '0;
    end else begin
      r_prev_bit <= i_time_bit;
      r_armed    <= 1'b1;
      if (!w_active) begin
        r_slot_idx <= '0;
      end else if (o_boundary) begin
        r_slot_idx <= w_wrap ? '0 : r_slot_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_sensitive_injection_scheduler.sv
// Time-sensitive injection scheduler top level.
// Reads one schedule RAM entry per time slot and raises a req/ack injection
// request for each valid entry. Define SCHED_STAT_EN to add the inject and
// miss statistic counters (ov_inject_cnt, ov_miss_cnt).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a slot boundary
// ST_READ  | one-cycle RAM read strobe at the new slot index
// ST_WAIT  | counting down RAM read latency, then sample the entry
// ST_ISSUE | request held until ack; a boundary without ack drops it
module time_sensitive_injection_scheduler
  import time_sensitive_injection_scheduler_pkg::*;
#(
  parameter int SLOT_SHIFT = 10,
  parameter int RD_LAT     = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [63:0]         iv_syn_clk,
  input  logic                i_sched_en,
  input  logic [IDX_W-1:0]    iv_period,
  output logic [IDX_W-1:0]    ov_ram_raddr,
  output logic                o_ram_rd,
  input  logic [15:0]         iv_ram_rdata,
  output logic                o_inject_req,
  output logic [FLOWID_W-1:0] ov_inject_flowid,
  input  logic                i_inject_ack,
  output logic                o_slot_miss,
  output logic [IDX_W-1:0]    ov_slot_idx
`ifdef SCHED_STAT_EN
  ,
  output logic [31:0]         ov_inject_cnt,
  output logic [15:0]         ov_miss_cnt
`endif
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LAT - 1);

  sched_state_t        r_state;
  sched_state_t        w_state_nxt;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [CNT_W-1:0]    w_wait_cnt_nxt;
  logic [FLOWID_W-1:0] r_flowid;
  logic [FLOWID_W-1:0] w_flowid_nxt;

  logic                w_boundary;
  logic [IDX_W-1:0]    w_slot_idx;
  logic                w_ack_take;
  logic                w_miss;
  logic                w_unused;

  tsi_slot_tracker u_slot_tracker (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_time_bit  (iv_syn_clk[SLOT_SHIFT]),
    .i_sched_en  (i_sched_en),
    .iv_period   (iv_period),
    .o_boundary  (w_boundary),
    .ov_slot_idx (w_slot_idx)
  );

  assign ov_ram_raddr     = w_slot_idx;
  assign ov_slot_idx      = w_slot_idx;
  assign o_inject_req     = (r_state == ST_ISSUE);
  assign ov_inject_flowid = r_flowid;
  assign o_slot_miss      = w_miss;

  // State, latency counter and latched flow ID registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_flowid   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_flowid   <= w_flowid_nxt;
    end
  end

  // Next-state, read strobe, ack acceptance and miss detection.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_flowid_nxt   = r_flowid;
    o_ram_rd       = 1'b0;
    w_ack_take     = 1'b0;
    w_miss         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_boundary) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        o_ram_rd       = 1'b1;
        w_wait_cnt_nxt = WAIT_INIT;
        w_state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        // Boundaries here are deliberately ignored: the slot is too short.
        if (r_wait_cnt != '0) begin
          w_wait_cnt_nxt = r_wait_cnt - CNT_W'(1);
        end else if (iv_ram_rdata[ENTRY_VALID_BIT]) begin
          w_flowid_nxt = iv_ram_rdata[FLOWID_MSB:FLOWID_LSB];
          w_state_nxt  = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Ack beats a coincident boundary; the new slot is still processed.
        if (i_inject_ack) begin
          w_ack_take   = 1'b1;
          w_flowid_nxt = '0;
          w_state_nxt  = w_boundary ? ST_READ : ST_IDLE;
        end else if (w_boundary) begin
          w_miss       = 1'b1;
          w_flowid_nxt = '0;
          w_state_nxt  = ST_READ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Disabling abandons any transaction silently (no ack, no miss).
    if (!i_sched_en) begin
      w_state_nxt  = ST_IDLE;
      w_flowid_nxt = '0;
      w_ack_take   = 1'b0;
      w_miss       = 1'b0;
    end
  end

`ifdef SCHED_STAT_EN
  logic [31:0] r_inject_cnt;
  logic [15:0] r_miss_cnt;

  // Accepted-injection counter wraps; miss counter saturates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inject_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_ack_take) r_inject_cnt <= r_inject_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign ov_inject_cnt = r_inject_cnt;
  assign ov_miss_cnt   = r_miss_cnt;

  assign w_unused = ^{iv_syn_clk[63:SLOT_SHIFT+1], iv_syn_clk[SLOT_SHIFT-1:0],
                      iv_ram_rdata[ENTRY_RSVD_BIT]};
`else
  assign w_unused = ^{iv_syn_clk[63:SLOT_SHIFT+1], iv_syn_clk[SLOT_SHIFT-1:0],
                      iv_ram_rdata[ENTRY_RSVD_BIT], w_ack_take};
`endif

endmodule

// File: tb/tb_time_sensitive_injection_scheduler.sv
// Testbench for time_sensitive_injection_scheduler: directed vector table,
// hand-written enable-drop and reset sequences, and a randomized run against
// a slot-level reference model. Builds with or without SCHED_STAT_EN.
module tb_time_sensitive_injection_scheduler;

  localparam int RD_LAT   = 2;
  localparam int SLOT_CYC = 16;
  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_BND    = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [63:0] iv_syn_clk;
  logic        i_sched_en;
  logic [9:0]  iv_period;
  logic [9:0]  ov_ram_raddr;
  logic        o_ram_rd;
  logic [15:0] iv_ram_rdata;
  logic        o_inject_req;
  logic [13:0] ov_inject_flowid;
  logic        i_inject_ack;
  logic        o_slot_miss;
  logic [9:0]  ov_slot_idx;
`ifdef SCHED_STAT_EN
  logic [31:0] ov_inject_cnt;
  logic [15:0] ov_miss_cnt;
`endif

  time_sensitive_injection_scheduler #(.SLOT_SHIFT(10), .RD_LAT(RD_LAT)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .iv_syn_clk       (iv_syn_clk),
    .i_sched_en       (i_sched_en),
    .iv_period        (iv_period),
    .ov_ram_raddr     (ov_ram_raddr),
    .o_ram_rd         (o_ram_rd),
    .iv_ram_rdata     (iv_ram_rdata),
    .o_inject_req     (o_inject_req),
    .ov_inject_flowid (ov_inject_flowid),
    .i_inject_ack     (i_inject_ack),
    .o_slot_miss      (o_slot_miss),
    .ov_slot_idx      (ov_slot_idx)
`ifdef SCHED_STAT_EN
    ,
    .ov_inject_cnt    (ov_inject_cnt),
    .ov_miss_cnt      (ov_miss_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // RAM model: data appears RD_LAT cycles after the strobe; garbage with the
  // valid bit set otherwise, so mistimed sampling shows up as a bogus request.
  logic [15:0] mem [1024];
  logic [16:0] pipe [RD_LAT];
  initial for (int k = 0; k < RD_LAT; k++) pipe[k] = '0;
  always @(posedge i_clk) begin
    pipe[0] <= o_ram_rd ? {1'b1, mem[ov_ram_raddr]} : 17'h0;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign iv_ram_rdata = pipe[RD_LAT-1][16] ? pipe[RD_LAT-1][15:0] : 16'hBEEF;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_ack_exp = 0;
  int          n_miss_exp = 0;
  logic        ack_at_bnd = 1'b0;
  logic [63:0] t_now;

  typedef struct {
    logic       en;
    logic [9:0] per;
    int         mode;
    logic       e_miss;
    logic       e_rd;
    logic [9:0] e_idx;
    logic       e_req;
    logic [13:0] e_fid;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] noisy_time();
    return t_now | 64'($urandom_range(0, 1023));
  endfunction

  // One slot: boundary at c0, read at c1, request at c(2+RD_LAT), then
  // ack according to mode; returns on the last cycle before the next boundary.
  task automatic do_slot(input logic en, input logic [9:0] per, input int mode,
                         input logic e_miss, input logic e_rd, input logic [9:0] e_idx,
                         input logic e_req, input logic [13:0] e_fid);
    int c;
    step();
    i_sched_en   = en;
    iv_period    = per;
    t_now        = t_now + 64'd1024;
    iv_syn_clk   = noisy_time();
    i_inject_ack = ack_at_bnd;
    #1;
    chk("slot_miss", 32'(o_slot_miss), 32'(e_miss));
    if (e_miss) n_miss_exp++;
    if (ack_at_bnd) n_ack_exp++;
    step();
    i_inject_ack = 1'b0;
    #1;
    chk("ram_rd", 32'(o_ram_rd), 32'(e_rd));
    chk("slot_idx", 32'(ov_slot_idx), 32'(e_idx));
    if (e_rd) chk("ram_raddr", 32'(ov_ram_raddr), 32'(e_idx));
    chk("req_after_bnd", 32'(o_inject_req), 32'd0);
    c = 1;
    while (c < 1 + RD_LAT) begin
      step();
      c++;
      iv_syn_clk = noisy_time();
      #1;
      if (c == 2) chk("ram_rd_pulse", 32'(o_ram_rd), 32'd0);
      chk("req_early", 32'(o_inject_req), 32'd0);
    end
    step();
    c++;
    #1;
    chk("inject_req", 32'(o_inject_req), 32'(e_req));
    chk("inject_flowid", 32'(ov_inject_flowid), e_req ? 32'(e_fid) : 32'd0);
    if (e_req && mode == M_ACK) begin
      step();
      c++;
      i_inject_ack = 1'b1;
      #1;
      chk("req_hold", 32'(o_inject_req), 32'd1);
      chk("flowid_hold", 32'(ov_inject_flowid), 32'(e_fid));
      step();
      c++;
      i_inject_ack = 1'b0;
      #1;
      chk("req_after_ack", 32'(o_inject_req), 32'd0);
      chk("flowid_after_ack", 32'(ov_inject_flowid), 32'd0);
      n_ack_exp++;
    end
    while (c < SLOT_CYC - 1) begin
      step();
      c++;
      iv_syn_clk = noisy_time();
    end
    #1;
    if (e_req && mode != M_ACK) begin
      chk("req_held", 32'(o_inject_req), 32'd1);
      chk("flowid_held", 32'(ov_inject_flowid), 32'(e_fid));
    end
    ack_at_bnd = e_req && (mode == M_BND);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int          m_idx;
    logic        m_pend;
    logic [9:0]  per;
    int          mode;
    logic        miss;
    logic [15:0] ent;

    vecs[0]  = '{1'b1, 10'd4, M_ACK,   1'b0, 1'b1, 10'd1, 1'b1, 14'h0005};
    vecs[1]  = '{1'b1, 10'd4, M_ACK,   1'b0, 1'b1, 10'd2, 1'b0, 14'h0000};
    vecs[2]  = '{1'b1, 10'd4, M_NOACK, 1'b0, 1'b1, 10'd3, 1'b1, 14'h000A};
    vecs[3]  = '{1'b1, 10'd4, M_ACK,   1'b1, 1'b1, 10'd0, 1'b0, 14'h0000};
    vecs[4]  = '{1'b1, 10'd3, M_BND,   1'b0, 1'b1, 10'd1, 1'b1, 14'h0005};
    vecs[5]  = '{1'b1, 10'd3, M_ACK,   1'b0, 1'b1, 10'd2, 1'b0, 14'h0000};
    vecs[6]  = '{1'b1, 10'd3, M_ACK,   1'b0, 1'b1, 10'd0, 1'b0, 14'h0000};
    vecs[7]  = '{1'b1, 10'd3, M_ACK,   1'b0, 1'b1, 10'd1, 1'b1, 14'h0005};
    vecs[8]  = '{1'b1, 10'd3, M_ACK,   1'b0, 1'b1, 10'd2, 1'b0, 14'h0000};
    vecs[9]  = '{1'b1, 10'd3, M_ACK,   1'b0, 1'b1, 10'd0, 1'b0, 14'h0000};
    vecs[10] = '{1'b1, 10'd3, M_ACK,   1'b0, 1'b1, 10'd1, 1'b1, 14'h0005};
    vecs[11] = '{1'b1, 10'd0, M_ACK,   1'b0, 1'b0, 10'd0, 1'b0, 14'h0000};
    vecs[12] = '{1'b1, 10'd0, M_ACK,   1'b0, 1'b0, 10'd0, 1'b0, 14'h0000};
    vecs[13] = '{1'b1, 10'd0, M_ACK,   1'b0, 1'b0, 10'd0, 1'b0, 14'h0000};
    vecs[14] = '{1'b0, 10'd3, M_ACK,   1'b0, 1'b0, 10'd0, 1'b0, 14'h0000};
    vecs[15] = '{1'b0, 10'd3, M_ACK,   1'b0, 1'b0, 10'd0, 1'b0, 14'h0000};
    vecs[16] = '{1'b1, 10'd3, M_ACK,   1'b0, 1'b1, 10'd1, 1'b1, 14'h0005};
    vecs[17] = '{1'b1, 10'd2, M_ACK,   1'b0, 1'b1, 10'd0, 1'b0, 14'h0000};
    vecs[18] = '{1'b1, 10'd4, M_ACK,   1'b0, 1'b1, 10'd1, 1'b1, 14'h0005};
    vecs[19] = '{1'b1, 10'd4, M_ACK,   1'b0, 1'b1, 10'd2, 1'b0, 14'h0000};
    vecs[20] = '{1'b1, 10'd4, M_ACK,   1'b0, 1'b1, 10'd3, 1'b1, 14'h000A};
    vecs[21] = '{1'b1, 10'd2, M_ACK,   1'b0, 1'b1, 10'd0, 1'b0, 14'h0000};

    for (int k = 0; k < 1024; k++) mem[k] = 16'h0000;
    mem[1] = 16'h8005;
    mem[2] = 16'h0007;
    mem[3] = 16'hC00A;

    // Reset state
    i_rst        = 1'b1;
    t_now        = 64'h400;
    iv_syn_clk   = t_now;
    i_sched_en   = 1'b0;
    iv_period    = 10'd0;
    i_inject_ack = 1'b0;
    repeat (3) step();
    chk("rst_ram_rd", 32'(o_ram_rd), 32'd0);
    chk("rst_req", 32'(o_inject_req), 32'd0);
    chk("rst_flowid", 32'(ov_inject_flowid), 32'd0);
    chk("rst_miss", 32'(o_slot_miss), 32'd0);
    chk("rst_slot_idx", 32'(ov_slot_idx), 32'd0);
    chk("rst_raddr", 32'(ov_ram_raddr), 32'd0);
    i_rst      = 1'b0;
    i_sched_en = 1'b1;
    iv_period  = 10'd4;
    step();
    step();
    chk("post_rst_rd", 32'(o_ram_rd), 32'd0);
    chk("post_rst_idx", 32'(ov_slot_idx), 32'd0);

    // Directed table
    for (int i = 0; i < 22; i++)
      do_slot(vecs[i].en, vecs[i].per, vecs[i].mode, vecs[i].e_miss, vecs[i].e_rd,
              vecs[i].e_idx, vecs[i].e_req, vecs[i].e_fid);

    // Enable dropped while a request is pending: silent cancel
    do_slot(1'b1, 10'd4, M_NOACK, 1'b0, 1'b1, 10'd1, 1'b1, 14'h0005);
    step();
    i_sched_en = 1'b0;
    #1;
    chk("endrop_miss0", 32'(o_slot_miss), 32'd0);
    chk("endrop_req_still", 32'(o_inject_req), 32'd1);
    step();
    chk("endrop_req", 32'(o_inject_req), 32'd0);
    chk("endrop_flowid", 32'(ov_inject_flowid), 32'd0);
    chk("endrop_miss1", 32'(o_slot_miss), 32'd0);
    chk("endrop_idx", 32'(ov_slot_idx), 32'd0);
    step();
    i_sched_en = 1'b1;
    m_idx      = 0;
    m_pend     = 1'b0;

    // Randomized slots against the slot-level model
    for (int k = 0; k < 8; k++) mem[k] = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      per  = 10'($urandom_range(1, 6));
      mode = (i == 39) ? M_ACK : int'($urandom_range(0, 2));
      miss = m_pend;
      m_idx = (m_idx >= int'(per) - 1) ? 0 : m_idx + 1;
      ent  = mem[m_idx];
      do_slot(1'b1, per, mode, miss, 1'b1, 10'(m_idx), ent[15], ent[13:0]);
      m_pend = ent[15] && (mode == M_NOACK);
    end

`ifdef SCHED_STAT_EN
    chk("inject_cnt", ov_inject_cnt, 32'(n_ack_exp));
    chk("miss_cnt", 32'(ov_miss_cnt), 32'(n_miss_exp));
`endif

    // Reset in the middle of WAIT, with the time bit flipped during reset
    step();
    t_now      = t_now + 64'd1024;
    iv_syn_clk = t_now;
    iv_period  = 10'd4;
    step();
    chk("rstw_read", 32'(o_ram_rd), 32'd1);
    step();
    i_rst = 1'b1;
    t_now = t_now + 64'd1024;
    if (!t_now[10]) t_now = t_now + 64'd1024;
    iv_syn_clk = t_now;
    step();
    i_rst = 1'b0;
    #1;
    chk("rstw_rd", 32'(o_ram_rd), 32'd0);
    chk("rstw_req", 32'(o_inject_req), 32'd0);
    chk("rstw_flowid", 32'(ov_inject_flowid), 32'd0);
    chk("rstw_miss", 32'(o_slot_miss), 32'd0);
    chk("rstw_idx", 32'(ov_slot_idx), 32'd0);
`ifdef SCHED_STAT_EN
    chk("rstw_inject_cnt", ov_inject_cnt, 32'd0);
    chk("rstw_miss_cnt", 32'(ov_miss_cnt), 32'd0);
`endif
    step();
    chk("rstw_no_spurious_rd", 32'(o_ram_rd), 32'd0);
    chk("rstw_no_spurious_idx", 32'(ov_slot_idx), 32'd0);
    ack_at_bnd = 1'b0;
    n_ack_exp  = 0;
    n_miss_exp = 0;
    do_slot(1'b1, 10'd4, M_ACK, 1'b0, 1'b1, 10'd1, mem[1][15], mem[1][13:0]);
`ifdef SCHED_STAT_EN
    chk("final_inject_cnt", ov_inject_cnt, 32'(n_ack_exp));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
